elastic_fifo_v: RTL



---
 rtl/elastic_fifo_v_if.sv | 29 ++
 rtl/elastic_fifo_v.sv | 104 ++++++++++
 2 files changed

// File: rtl/elastic_fifo_v_if.sv
// Valid/ready bundle for the elastic FIFO: write side, read side, flush and status.
// The slave modport is the FIFO; the master modport is the producer/consumer side.
interface elastic_fifo_v_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32
) ();
    localparam int CW = $clog2(FIFO_DEPTH + 2);

    logic                  flush;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_v;
    logic                  din_r;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_v;
    logic                  dout_r;
    logic [CW-1:0]         count;
    logic                  almost_full;
    logic                  almost_empty;

    modport slave (
        input  flush, din, din_v, dout_r,
        output din_r, dout, dout_v, count, almost_full, almost_empty
    );

    modport master (
        output flush, din, din_v, dout_r,
        input  din_r, dout, dout_v, count, almost_full, almost_empty
    );
endinterface

// File: rtl/elastic_fifo_v.sv
// Elastic valid/ready buffer: FIFO_DEPTH-entry array plus one registered output slot,
// with empty-buffer bypass, synchronous flush, occupancy count and almost-full/empty flags.
module elastic_fifo_v #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 32,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input logic             clock,
    input logic             reset,
    elastic_fifo_v_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 2);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PW-1:0]         wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]         mem_cnt_q, mem_cnt_d;
    logic [DATA_WIDTH-1:0] dout_q,    dout_d;
    logic                  dout_v_q,  dout_v_d;
    logic [CW-1:0]         count_q,   count_d;
    logic                  afull_q,   afull_d;
    logic                  aempty_q,  aempty_d;

    logic din_r, clear, out_free, wr_fire, pop, bypass, push;

    // Ready depends only on array occupancy, never on dout_r.
    assign din_r = (mem_cnt_q != DEPTH_C);
    assign clear = reset || bus.flush;

    always_comb begin
        out_free = !dout_v_q || bus.dout_r;
        wr_fire  = bus.din_v && din_r;
        pop      = out_free && (mem_cnt_q != '0);
        bypass   = out_free && (mem_cnt_q == '0) && wr_fire;
        push     = wr_fire && !bypass;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dout_d    = dout_q;
        dout_v_d  = dout_v_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            dout_d   = mem_q[rd_ptr_q];
            dout_v_d = 1'b1;
        end else if (bypass) begin
            dout_d   = bus.din;
            dout_v_d = 1'b1;
        end else if (out_free) begin
            dout_v_d = 1'b0;
        end
        mem_cnt_d = mem_cnt_q + CW'(push) - CW'(pop);
        count_d   = mem_cnt_d + CW'(dout_v_d);
        afull_d   = (count_d >= AFULL_C);
        aempty_d  = (count_d <= AEMPTY_C);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            dout_q    <= '0;
            dout_v_q  <= 1'b0;
            count_q   <= '0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            dout_q    <= dout_d;
            dout_v_q  <= dout_v_d;
            count_q   <= count_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    // Array contents are not reset; only the pointers and counts define validity.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.din_r        = din_r;
    assign bus.dout         = dout_q;
    assign bus.dout_v       = dout_v_q;
    assign bus.count        = count_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
endmodule
